pipelined_aggregator: RTL and testbench

// Pipelined, flow-controlled successor to the combinational aggregator hierarchy.
// - Accepts request_t beats on a valid/ready input.
// - Re-tags the id by ID_INC and fans each beat into COUNT parametrised leaf lanes.
// - Reduces the lanes by XOR or modular sum (selected per beat).
// - Presents the result on a valid/ready output after a 2-stage register pipeline.
// - Sits between the request front end and any consumer that can apply backpressure.

---
 rtl/pipelined_aggregator.sv | 177 +++++++++++++++++
 tb/tb_pipelined_aggregator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_aggregator
// Description : Flow-controlled, two-stage pipelined aggregator. Accepts
//               request beats {data[15:0], id[3:0], valid} on a valid/ready
//               input, re-tags the id by ID_INC (mod 16) and fans the beat
//               into COUNT shifted leaf lanes. The lanes are reduced by XOR
//               or by modular sum, selected per beat. The result appears on
//               a valid/ready output two cycles after acceptance.
// Ports       :
//   clk        in   1      single clock, all state on posedge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      input beat present
//   in_ready   out  1      block can accept a beat this cycle
//   in_req     in   21     {data[15:0], id[3:0], valid}
//   in_mode    in   1      0 = XOR reduce, 1 = sum mod 2^WIDTH
//   out_valid  out  1      result beat present
//   out_ready  in   1      consumer accepts the result this cycle
//   out_data   out  WIDTH  reduced result
//   out_id     out  4      re-tagged id
//   beat_count out  CNT_W  number of accepted input beats (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_aggregator #(
  parameter int WIDTH       = 16,  // >= 16, data is zero-extended to WIDTH
  parameter int COUNT       = 3,   // number of leaf lanes, 1..8
  parameter int OFFSET_STEP = 2,   // lane g shifts right by g*OFFSET_STEP
  parameter int ID_INC      = 1,   // id re-tag increment, modulo 16
  parameter int CNT_W       = 16   // accepted-beat counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [20:0]      in_req,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_id,
  output logic [CNT_W-1:0] beat_count
);

  localparam logic [3:0] c_ID_INC4 = 4'(ID_INC % 16);

  // --------------------------------------------------------------------------
  // Request field extraction
  // --------------------------------------------------------------------------
  logic [15:0] w_req_data;
  logic [3:0]  w_req_id;
  logic        w_req_pv;
  logic [3:0]  w_req_id_retag;

  assign w_req_data     = in_req[20:5];
  assign w_req_id       = in_req[4:1];
  assign w_req_pv       = in_req[0];
  // 4-bit add wraps naturally, giving the modulo-16 re-tag.
  assign w_req_id_retag = w_req_id + c_ID_INC4;

  // --------------------------------------------------------------------------
  // Flow control
  // --------------------------------------------------------------------------
  logic r_s1_v;
  logic r_s2_v;
  logic w_s2_adv;
  logic w_s1_adv;
  logic w_in_xfer;

  // S2 can take new content when empty or when its beat leaves this cycle.
  assign w_s2_adv  = !r_s2_v || out_ready;
  // S1 can take new content when empty or when it can hand off to S2.
  assign w_s1_adv  = !r_s1_v || w_s2_adv;
  // No skid buffer: readiness is combinational from out_ready.
  assign in_ready  = w_s1_adv;
  assign w_in_xfer = in_valid && w_s1_adv;

  // --------------------------------------------------------------------------
  // Stage S1: captured request
  // --------------------------------------------------------------------------
  logic [15:0] r_s1_data;
  logic [3:0]  r_s1_id;
  logic        r_s1_pv;
  logic        r_s1_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_s1_id   <= '0;
      r_s1_pv   <= 1'b0;
      r_s1_mode <= 1'b0;
    end else if (w_s1_adv) begin
      // When S1 advances it either loads the incoming beat or empties.
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_data <= w_req_data;
        r_s1_id   <= w_req_id_retag;
        r_s1_pv   <= w_req_pv;
        r_s1_mode <= in_mode;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Leaf lanes and reduction (combinational between S1 and S2)
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_data_ext;
  logic [WIDTH-1:0] w_id_mask;
  logic [WIDTH-1:0] w_lane [COUNT];
  logic [WIDTH-1:0] w_red_xor;
  logic [WIDTH-1:0] w_red_sum;
  logic [WIDTH-1:0] w_reduced;

  assign w_data_ext = WIDTH'(r_s1_data);
  // The id only mixes into the lanes when the payload valid bit is set.
  assign w_id_mask  = r_s1_pv ? WIDTH'(r_s1_id) : '0;

  for (genvar g = 0; g < COUNT; g++) begin : g_lane
    // Shifts at or beyond WIDTH simply yield zero before the id mix.
    assign w_lane[g] = (w_data_ext >> (g * OFFSET_STEP)) ^ w_id_mask;
  end

  always_comb begin
    w_red_xor = '0;
    w_red_sum = '0;
    for (int i = 0; i < COUNT; i++) begin
      w_red_xor = w_red_xor ^ w_lane[i];
      // Sum is carried at WIDTH bits, so overflow truncates (mod 2^WIDTH).
      w_red_sum = w_red_sum + w_lane[i];
    end
  end

  assign w_reduced = r_s1_mode ? w_red_sum : w_red_xor;

  // --------------------------------------------------------------------------
  // Stage S2: output register
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_out_data;
  logic [3:0]       r_out_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v     <= 1'b0;
      r_out_data <= '0;
      r_out_id   <= '0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      // Payload only updates with a real beat, so a drained output keeps
      // its last value rather than picking up stale S1 content.
      if (r_s1_v) begin
        r_out_data <= w_reduced;
        r_out_id   <= r_s1_id;
      end
    end
  end

  assign out_valid = r_s2_v;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;

  // --------------------------------------------------------------------------
  // Accepted-beat counter (wraps, never saturates)
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_beat_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_count <= '0;
    end else if (w_in_xfer) begin
      r_beat_count <= r_beat_count + CNT_W'(1);
    end
  end

  assign beat_count = r_beat_count;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_aggregator
// Description : Self-checking bench for pipelined_aggregator. Two instances
//               share the stimulus: one with the default 16-bit counter and
//               one with a 4-bit counter for the wrap case. A queue-based
//               model tracks beats in flight and predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_aggregator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [20:0] in_req = '0;
  logic        in_mode = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, in_ready4;
  logic        out_valid, out_valid4;
  logic [15:0] out_data, out_data4;
  logic [3:0]  out_id, out_id4;
  logic [15:0] beat_count;
  logic [3:0]  beat_count4;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  always #5 clk = ~clk;

  pipelined_aggregator #(.WIDTH(16), .COUNT(3), .OFFSET_STEP(2), .ID_INC(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .beat_count(beat_count));

  pipelined_aggregator #(.WIDTH(16), .COUNT(3), .OFFSET_STEP(2), .ID_INC(1), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_req(in_req),
    .in_mode(in_mode), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_id(out_id4), .beat_count(beat_count4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the lane definition: three lanes, lane g
  // is data shifted right by 2*g, XORed with the new id if payload valid.
  function automatic logic [15:0] ref_result(input logic [15:0] d, input logic [3:0] new_id,
                                             input logic pv, input logic mode);
    logic [15:0] acc;
    logic [15:0] lane;
    acc = 16'h0000;
    for (int g = 0; g < 3; g++) begin
      lane = (d >> (2 * g)) ^ (pv ? {12'h000, new_id} : 16'h0000);
      if (mode) acc = acc + lane;
      else      acc = acc ^ lane;
    end
    return acc;
  endfunction

  // ---------------------------------------------------------------------------
  // Model: beats in flight as a queue. At most two are in flight; the head is
  // visible at the output once two cycles have passed since its acceptance,
  // and a slot frees in the same cycle the head drains.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] data;
    logic [3:0]  id;
    int          acc_cycle;
  } beat_t;

  beat_t q[$];
  int    model_cnt = 0;
  int    cycle = 0;
  bit    armed = 0;

  initial begin : compare_proc
    bit    exp_ov;
    bit    exp_ir;
    bit    in_x;
    bit    out_x;
    beat_t nb;
    in_x  = 0;
    out_x = 0;
    forever begin
      @(negedge clk);
      in_x  = 0;
      out_x = 0;
      if (armed) begin
        exp_ov = (q.size() > 0) && (cycle >= q[0].acc_cycle + 2);
        exp_ir = (q.size() < 2) || out_ready;
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        chk("out_valid4", {31'd0, out_valid4}, {31'd0, exp_ov});
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        chk("in_ready4", {31'd0, in_ready4}, {31'd0, exp_ir});
        chk("beat_count", {16'd0, beat_count}, model_cnt & 32'hFFFF);
        chk("beat_count4", {28'd0, beat_count4}, model_cnt & 32'hF);
        if (exp_ov) begin
          chk("out_data", {16'd0, out_data}, {16'd0, q[0].data});
          chk("out_id", {28'd0, out_id}, {28'd0, q[0].id});
          chk("out_data4", {16'd0, out_data4}, {16'd0, q[0].data});
        end
        in_x  = in_valid && exp_ir;
        out_x = exp_ov && out_ready;
        if (in_x) begin
          nb.id        = in_req[4:1] + 4'd1;
          nb.data      = ref_result(in_req[20:5], nb.id, in_req[0], in_mode);
          nb.acc_cycle = cycle;
        end
      end
      @(posedge clk);
      if (rst) begin
        q.delete();
        model_cnt = 0;
        armed     = 1;
      end else if (armed) begin
        if (out_x) begin
          void'(q.pop_front());
          n_out++;
        end
        if (in_x) begin
          q.push_back(nb);
          model_cnt++;
        end
      end
      cycle++;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic [3:0] id, input logic pv,
                       input logic mode);
    in_valid = 1'b1;
    in_req   = {d, id, pv};
    in_mode  = mode;
  endtask

  initial begin : stim_proc
    int n0;
    int seed_val;

    // Model pinning against hand-computed values.
    chk("ref_xor", {16'd0, ref_result(16'h00F0, 4'd3, 1'b1, 1'b0)}, 32'h00C0);
    chk("ref_sum", {16'd0, ref_result(16'h00F0, 4'd3, 1'b1, 1'b1)}, 32'h013E);
    chk("ref_nopv", {16'd0, ref_result(16'hFFFF, 4'd0, 1'b0, 1'b0)}, 32'hCFFF);

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", {16'd0, out_data}, 32'd0);
    chk("reset_out_id", {28'd0, out_id}, 32'd0);
    chk("reset_count", {16'd0, beat_count}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // 1. XOR reduction.
    out_ready = 1'b1;
    drive(16'h00F0, 4'd2, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_data", {16'd0, out_data}, 32'h00C0);
    chk("t1_id", {28'd0, out_id}, 32'd3);

    // 2. Sum reduction, then payload-invalid beat with id wrap.
    drive(16'h00F0, 4'd2, 1'b1, 1'b1);
    step();
    drive(16'hFFFF, 4'd15, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("t2_sum_data", {16'd0, out_data}, 32'h013E);
    chk("t2_sum_id", {28'd0, out_id}, 32'd3);
    step();
    chk("t2_wrap_data", {16'd0, out_data}, 32'hCFFF);
    chk("t2_wrap_id", {28'd0, out_id}, 32'd0);
    step();
    step();

    // 3. Backpressure: two beats fit, the third waits.
    out_ready = 1'b0;
    drive(16'h00F0, 4'd2, 1'b1, 1'b0);
    step();
    drive(16'h1234, 4'd5, 1'b1, 1'b1);
    step();
    drive(16'hA5A5, 4'd9, 1'b0, 1'b0);
    chk("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
    step();
    step();
    step();
    chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_hold_data", {16'd0, out_data}, 32'h00C0);
    chk("t3_hold_id", {28'd0, out_id}, 32'd3);
    n0 = n_out;
    out_ready = 1'b1;
    #1;
    chk("t3_in_ready_release", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t3_drained", n_out - n0, 32'd3);

    // 4. Streaming at full rate.
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      drive(16'(16'h1111 * (i + 1)), 4'(i * 3), i[0], i[1]);
      chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t4_count", n_out - n0, 32'd8);

    // 5. Reset with two beats in flight.
    drive(16'h0F0F, 4'd7, 1'b1, 1'b0);
    step();
    drive(16'hF00F, 4'd8, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_count", {16'd0, beat_count}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    n0 = n_out;
    for (int i = 0; i < 4; i++) step();
    chk("t5_no_ghosts", n_out - n0, 32'd0);

    // 6. Counter wrap on the 4-bit instance.
    for (int i = 0; i < 17; i++) begin
      drive(16'(i * 16'h0101), 4'(i), 1'b1, i[0]);
      step();
    end
    in_valid = 1'b0;
    chk("t6_wrap4", {28'd0, beat_count4}, 32'd1);
    chk("t6_count16", {16'd0, beat_count}, 32'd17);
    step();
    step();

    // Random traffic against the model.
    seed_val = 7;
    void'($urandom(seed_val));
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_req    = 21'($urandom);
      in_mode   = 1'($urandom_range(0, 1));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
